// File: rtl/tone_tracker_poly.sv
`default_nettype none
// ============================================================================
//  Module      : tone_tracker_poly
//  Description : Multi-channel frequency-to-note tracker. A start request
//                launches a scan that classifies one channel per cycle
//                against a note table with a +/-TOL window. Each channel
//                debounces its result so the committed note changes only
//                after STABLE_CNT consecutive identical classifications.
//  Ports       : clk, rst_n           - clock, async active-low reset
//                start                - scan request (honoured in IDLE only)
//                freq_in              - NUM_CH packed frequency words (Hz)
//                busy                 - high while scanning
//                done                 - one-cycle pulse at scan completion
//                note_num/octave/acc  - committed classification per channel
//                changed              - per-channel commit flags, valid with done
//  Revision    : 1.0 - initial release
// ============================================================================
module tone_tracker_poly #(
    parameter int NUM_CH     = 4,
    parameter int FREQ_W     = 32,
    parameter int TOL        = 2,
    parameter int STABLE_CNT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [NUM_CH*FREQ_W-1:0] freq_in,
    output logic                     busy,
    output logic                     done,
    output logic [NUM_CH*3-1:0]      note_num,
    output logic [NUM_CH*2-1:0]      octave,
    output logic [NUM_CH-1:0]        acc,
    output logic [NUM_CH-1:0]        changed
);

    localparam int          c_ch_w   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [1:0]  c_idle   = 2'd0;
    localparam logic [1:0]  c_scan   = 2'd1;
    localparam logic [1:0]  c_done   = 2'd2;
    localparam logic [3:0]  c_stable = 4'(STABLE_CNT);
    // Classification word layout: {acc, octave[1:0], note[2:0]}
    localparam logic [5:0]  c_none   = 6'b0_11_111;
    localparam int          c_rows   = 25;

    // Table row: {acc, octave, note, freq[9:0]}; earlier rows take priority.
    localparam logic [15:0] c_table [c_rows] = '{
        {1'b0, 2'd0, 3'd0, 10'd131}, {1'b0, 2'd0, 3'd1, 10'd147},
        {1'b0, 2'd0, 3'd2, 10'd165}, {1'b0, 2'd0, 3'd3, 10'd174},
        {1'b0, 2'd0, 3'd4, 10'd196}, {1'b0, 2'd0, 3'd5, 10'd220},
        {1'b0, 2'd0, 3'd6, 10'd247},
        {1'b0, 2'd1, 3'd0, 10'd262}, {1'b0, 2'd1, 3'd1, 10'd294},
        {1'b0, 2'd1, 3'd2, 10'd330}, {1'b0, 2'd1, 3'd3, 10'd349},
        {1'b0, 2'd1, 3'd4, 10'd392}, {1'b0, 2'd1, 3'd5, 10'd440},
        {1'b0, 2'd1, 3'd6, 10'd494},
        {1'b0, 2'd2, 3'd0, 10'd524}, {1'b0, 2'd2, 3'd1, 10'd588},
        {1'b0, 2'd2, 3'd2, 10'd660}, {1'b0, 2'd2, 3'd3, 10'd698},
        {1'b0, 2'd2, 3'd4, 10'd784}, {1'b0, 2'd2, 3'd5, 10'd880},
        {1'b0, 2'd2, 3'd6, 10'd988},
        {1'b1, 2'd1, 3'd2, 10'd311}, {1'b1, 2'd1, 3'd3, 10'd370},
        {1'b1, 2'd1, 3'd4, 10'd415}, {1'b1, 2'd1, 3'd6, 10'd466}
    };

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [c_ch_w-1:0] r_ch_idx;
    logic              w_last;
    logic [FREQ_W-1:0] w_freq;
    logic [FREQ_W-1:0] w_entry;
    logic [FREQ_W-1:0] w_diff;
    logic [5:0]        w_cls;
    logic              w_found;

    assign w_last = (r_ch_idx == c_ch_w'(NUM_CH - 1));
    assign busy   = (r_state == c_scan);
    assign done   = (r_state == c_done);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (start) w_state_nxt = c_scan;
            c_scan:  if (w_last) w_state_nxt = c_done;
            c_done:  w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch_idx <= '0;
        end else if (r_state == c_scan && !w_last) begin
            r_ch_idx <= r_ch_idx + c_ch_w'(1);
        end else if (r_state != c_scan) begin
            r_ch_idx <= '0;
        end
    end

    // Select the channel under scan and classify it. The absolute difference
    // is formed without wrap so small frequencies never alias onto entries.
    always_comb begin
        w_freq  = '0;
        w_entry = '0;
        w_diff  = '0;
        w_cls   = c_none;
        w_found = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_ch_idx == c_ch_w'(c)) w_freq = freq_in[c*FREQ_W +: FREQ_W];
        end
        for (int r = 0; r < c_rows; r++) begin
            w_entry = FREQ_W'(c_table[r][9:0]);
            w_diff  = (w_freq >= w_entry) ? (w_freq - w_entry) : (w_entry - w_freq);
            if (!w_found && (w_diff <= FREQ_W'(TOL))) begin
                w_found = 1'b1;
                w_cls   = c_table[r][15:10];
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            logic [5:0] r_cand;
            logic [5:0] r_com;
            logic [3:0] r_cnt;
            logic       r_chg;
            logic       w_hit;
            logic [3:0] w_cnt_nxt;

            assign w_hit     = (r_state == c_scan) && (r_ch_idx == c_ch_w'(g));
            assign w_cnt_nxt = (w_cls != r_cand) ? 4'd1 :
                               (r_cnt >= c_stable) ? c_stable : (r_cnt + 4'd1);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cand <= c_none;
                    r_com  <= c_none;
                    r_cnt  <= 4'd0;
                    r_chg  <= 1'b0;
                end else if (w_hit) begin
                    r_cand <= w_cls;
                    r_cnt  <= w_cnt_nxt;
                    if (w_cnt_nxt == c_stable && w_cls != r_com) begin
                        r_com <= w_cls;
                        r_chg <= 1'b1;
                    end
                end else if (r_state == c_done) begin
                    r_chg <= 1'b0;
                end
            end

            assign note_num[g*3 +: 3] = r_com[2:0];
            assign octave[g*2 +: 2]   = r_com[4:3];
            assign acc[g]             = r_com[5];
            assign changed[g]         = done & r_chg;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_tone_tracker_poly.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tone_tracker_poly
//  Description : Directed self-checking bench for tone_tracker_poly
//                (NUM_CH=4, FREQ_W=32, TOL=2, STABLE_CNT=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tone_tracker_poly;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [127:0]  freq_in;
    logic          busy;
    logic          done;
    logic [11:0]   note_num;
    logic [7:0]    octave;
    logic [3:0]    acc;
    logic [3:0]    changed;

    int            n_cmp;
    int            n_err;
    int            s_busy;
    logic [11:0]   s_note;
    logic [7:0]    s_oct;
    logic [3:0]    s_acc;
    logic [3:0]    s_chg;

    tone_tracker_poly #(
        .NUM_CH(4), .FREQ_W(32), .TOL(2), .STABLE_CNT(4)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .freq_in(freq_in),
        .busy(busy), .done(done), .note_num(note_num), .octave(octave),
        .acc(acc), .changed(changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic set_f(input int f0, input int f1, input int f2, input int f3);
        freq_in = {32'(f3), 32'(f2), 32'(f1), 32'(f0)};
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with it idle.
    task automatic do_scan();
        bit seen;
        seen   = 1'b0;
        s_busy = 0;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
            @(negedge clk);
            if (busy) s_busy++;
            if (done) begin
                seen   = 1'b1;
                s_note = note_num;
                s_oct  = octave;
                s_acc  = acc;
                s_chg  = changed;
            end
        end
        if (!seen) check("scan_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int flick [8] = '{440, 440, 440, 392, 440, 440, 440, 440};
        logic [3:0] chg_or;
        int n_done;
        int n_busy;

        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        set_f(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_busy",    32'(busy),     32'd0);
        check("rst_done",    32'(done),     32'd0);
        check("rst_note",    32'(note_num), 32'hFFF);
        check("rst_oct",     32'(octave),   32'hFF);
        check("rst_acc",     32'(acc),      32'h0);
        check("rst_changed", 32'(changed),  32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Stability count on ch0 at 262 Hz
        set_f(262, 0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            do_scan();
            check("c4_pre_chg",  32'(s_chg),      32'h0);
            check("c4_pre_note", 32'(s_note[2:0]), 32'd7);
        end
        do_scan();
        check("c4_busy", 32'(s_busy),      32'd4);
        check("c4_note", 32'(s_note[2:0]), 32'd0);
        check("c4_oct",  32'(s_oct[1:0]),  32'd1);
        check("c4_acc",  32'(s_acc[0]),    32'd0);
        check("c4_chg",  32'(s_chg),       32'h1);
        do_scan();
        check("c4_hold_chg", 32'(s_chg), 32'h0);

        // Tolerance window
        set_f(264, 0, 0, 0);
        repeat (4) do_scan();
        check("t264_note", 32'(s_note[2:0]), 32'd0);
        check("t264_oct",  32'(s_oct[1:0]),  32'd1);
        check("t264_chg",  32'(s_chg),       32'h0);
        set_f(265, 0, 0, 0);
        repeat (3) do_scan();
        check("t265_pre", 32'(s_note[2:0]), 32'd0);
        do_scan();
        check("t265_note", 32'(s_note[2:0]), 32'd7);
        check("t265_oct",  32'(s_oct[1:0]),  32'd3);
        check("t265_chg",  32'(s_chg),       32'h1);
        set_f(129, 0, 0, 0);
        repeat (4) do_scan();
        check("t129_note", 32'(s_note[2:0]), 32'd0);
        check("t129_oct",  32'(s_oct[1:0]),  32'd0);
        check("t129_chg",  32'(s_chg),       32'h1);
        set_f(0, 0, 0, 0);
        repeat (4) do_scan();
        check("t0_note", 32'(s_note[2:0]), 32'd7);
        check("t0_oct",  32'(s_oct[1:0]),  32'd3);
        check("t0_chg",  32'(s_chg),       32'h1);

        // Flicker resets the stability count
        chg_or = 4'h0;
        for (int i = 0; i < 7; i++) begin
            set_f(flick[i], 0, 0, 0);
            do_scan();
            chg_or = chg_or | s_chg;
        end
        check("flk_pre_chg",  32'(chg_or),      32'h0);
        check("flk_pre_note", 32'(s_note[2:0]), 32'd7);
        set_f(flick[7], 0, 0, 0);
        do_scan();
        check("flk_note", 32'(s_note[2:0]), 32'd5);
        check("flk_oct",  32'(s_oct[1:0]),  32'd1);
        check("flk_chg",  32'(s_chg),       32'h1);

        // Accidentals and top of the high octave
        set_f(311, 0, 0, 0);
        repeat (4) do_scan();
        check("a311", 32'({s_acc[0], s_oct[1:0], s_note[2:0]}), 32'b1_01_010);
        set_f(466, 0, 0, 0);
        repeat (4) do_scan();
        check("a466", 32'({s_acc[0], s_oct[1:0], s_note[2:0]}), 32'b1_01_110);
        set_f(988, 0, 0, 0);
        repeat (4) do_scan();
        check("a988", 32'({s_acc[0], s_oct[1:0], s_note[2:0]}), 32'b0_10_110);

        // Four independent channels
        set_f(262, 0, 880, 415);
        repeat (3) do_scan();
        check("mc_pre_chg", 32'(s_chg), 32'h0);
        do_scan();
        check("mc_note", 32'(s_note), 32'h978);
        check("mc_oct",  32'(s_oct),  32'h6D);
        check("mc_acc",  32'(s_acc),  32'h8);
        check("mc_chg",  32'(s_chg),  32'hD);
        check("mc_busy", 32'(s_busy), 32'd4);

        // Start pulses while busy are ignored
        n_done = 0;
        n_busy = 0;
        start  = 1'b1;
        @(posedge clk);
        for (int cyc = 0; cyc < 15; cyc++) begin
            @(negedge clk);
            if (cyc == 2) start = 1'b0;
            if (busy) n_busy++;
            if (done) n_done++;
        end
        check("ign_done", 32'(n_done), 32'd1);
        check("ign_busy", 32'(n_busy), 32'd4);

        // Reset in the middle of a scan (channel 2 pending)
        n_done = 0;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_note", 32'(note_num), 32'hFFF);
        check("mrst_oct",  32'(octave),   32'hFF);
        check("mrst_acc",  32'(acc),      32'h0);
        check("mrst_busy", 32'(busy),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("mrst_nodone", 32'(n_done), 32'd0);
        repeat (3) do_scan();
        check("mrst_pre_note", 32'(s_note), 32'hFFF);
        check("mrst_pre_chg",  32'(s_chg),  32'h0);
        do_scan();
        check("mrst_note4", 32'(s_note), 32'h978);
        check("mrst_chg4",  32'(s_chg),  32'hD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
